// File: rtl/ff_stream_loader_pkg.sv
// Shared constants and types for the feed-forward stream loader.
// The marker values are also decoded by the engine, so they must stay in sync.
package ff_stream_loader_pkg;

  localparam logic [31:0] MARK_BIAS   = 32'h8000_0000;
  localparam logic [31:0] MARK_NEURON = 32'hFFFF_FFFF;
  localparam logic [31:0] MARK_END    = 32'hFFFF_FFF0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_LOADP,
    ST_BURST,
    ST_START,
    ST_DONE
  } state_e;

  // Payload words that alias a marker are flattened to +0.0.
  function automatic logic [31:0] sanitize_word(input logic [31:0] w);
    return ((w == MARK_BIAS) || (w == MARK_NEURON) || (w == MARK_END)) ? '0 : w;
  endfunction

  function automatic logic is_nan_marker(input logic [31:0] w);
    return (w == MARK_NEURON) || (w == MARK_END);
  endfunction

endpackage

// File: rtl/ff_word_buf.sv
// Simple dual-port word buffer: synchronous write, synchronous read with enable.
// The read register holds its value while re is low.
module ff_word_buf #(
  parameter int unsigned DEPTH  = 509,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ff_stream_loader.sv
// Collects a little-endian byte stream into 32-bit words, then replays them to the
// feed-forward engine as one gap-free burst with section markers, followed by start.
module ff_stream_loader
  import ff_stream_loader_pkg::*;
#(
  parameter int unsigned DEPTH      = 509,
  parameter int unsigned ADDR_W     = 9,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W-1:0] cfg_n_weight,
  input  logic [ADDR_W-1:0] cfg_n_bias,
  input  logic [ADDR_W-1:0] cfg_n_input,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [31:0]       ff_data,
  output logic              ff_load,
  output logic              ff_start,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              err_nan,
  output logic              err_overrun
);

  localparam int unsigned KW = ADDR_W + 1;
  localparam int unsigned SW = ADDR_W + 2;

  state_e            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       sh_q, sh_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, total_q, total_d;
  logic [KW-1:0]     k_q, k_d;
  logic [KW-1:0]     bnd_bias_q, bnd_bias_d, bnd_neur_q, bnd_neur_d, bnd_end_q, bnd_end_d;
  logic              err_cfg_q, err_cfg_d, err_nan_q, err_nan_d, err_ovr_q, err_ovr_d;

  logic [SW-1:0]     cfg_sum;
  logic              cfg_ok;
  logic [31:0]       word_raw;
  logic              we, re;
  logic [ADDR_W-1:0] raddr;
  logic [31:0]       rdata;
  logic              is_marker;
  logic [31:0]       marker_val;

  assign cfg_sum  = SW'(cfg_n_weight) + SW'(cfg_n_bias) + SW'(cfg_n_input);
  assign cfg_ok   = (cfg_n_weight != '0) && (cfg_n_bias != '0) && (cfg_n_input != '0)
                    && (cfg_sum <= SW'(DEPTH));
  assign word_raw = {rx_data, sh_q};

  ff_word_buf #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(sanitize_word(word_raw)),
    .re   (re),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Burst index k selects a marker at the latched section boundaries.
  always_comb begin
    is_marker  = 1'b1;
    marker_val = '0;
    if (k_q == bnd_bias_q)      marker_val = MARK_BIAS;
    else if (k_q == bnd_neur_q) marker_val = MARK_NEURON;
    else if (k_q == bnd_end_q)  marker_val = MARK_END;
    else                        is_marker  = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    sh_d       = sh_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    total_d    = total_q;
    k_d        = k_q;
    bnd_bias_d = bnd_bias_q;
    bnd_neur_d = bnd_neur_q;
    bnd_end_d  = bnd_end_q;
    err_cfg_d  = err_cfg_q;
    err_nan_d  = err_nan_q;
    err_ovr_d  = err_ovr_q;
    we         = 1'b0;
    re         = 1'b0;
    raddr      = rd_ptr_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          if (cfg_ok) begin
            state_d    = ST_COLLECT;
            bcnt_d     = '0;
            wr_ptr_d   = '0;
            total_d    = ADDR_W'(cfg_sum);
            bnd_bias_d = KW'(cfg_n_weight);
            bnd_neur_d = KW'(cfg_n_weight) + KW'(cfg_n_bias) + KW'(1);
            bnd_end_d  = KW'(cfg_sum) + KW'(2);
            err_cfg_d  = 1'b0;
            err_nan_d  = 1'b0;
            err_ovr_d  = 1'b0;
          end else begin
            state_d   = ST_IDLE;
            err_cfg_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (rx_valid) begin
          sh_d   = {rx_data, sh_q[23:8]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (is_nan_marker(word_raw)) err_nan_d = 1'b1;
            if (wr_ptr_d == total_q) state_d = ST_LOADP;
          end
        end
      end
      ST_LOADP: begin
        re       = 1'b1;
        raddr    = '0;
        rd_ptr_d = ADDR_W'(1);
        k_d      = '0;
        state_d  = ST_BURST;
      end
      ST_BURST: begin
        k_d = k_q + 1'b1;
        // Prefetch the next payload word only when this cycle consumed one.
        if (!is_marker && (rd_ptr_q != total_q)) begin
          re       = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (k_q == bnd_end_q) state_d = ST_START;
      end
      ST_START: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    if (rx_valid && (state_q != ST_COLLECT)) err_ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bcnt_q     <= '0;
      sh_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      total_q    <= '0;
      k_q        <= '0;
      bnd_bias_q <= '0;
      bnd_neur_q <= '0;
      bnd_end_q  <= '0;
      err_cfg_q  <= 1'b0;
      err_nan_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      sh_q       <= sh_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      total_q    <= total_d;
      k_q        <= k_d;
      bnd_bias_q <= bnd_bias_d;
      bnd_neur_q <= bnd_neur_d;
      bnd_end_q  <= bnd_end_d;
      err_cfg_q  <= err_cfg_d;
      err_nan_q  <= err_nan_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  always_comb begin
    ff_data = '0;
    if (state_q == ST_BURST) ff_data = is_marker ? marker_val : rdata;
  end

  assign ff_load     = (state_q == ST_LOADP);
  assign ff_start    = (state_q == ST_START) && logic'(AUTO_START);
  assign busy        = (state_q == ST_COLLECT) || (state_q == ST_LOADP)
                       || (state_q == ST_BURST) || (state_q == ST_START);
  assign done        = (state_q == ST_DONE);
  assign err_cfg     = err_cfg_q;
  assign err_nan     = err_nan_q;
  assign err_overrun = err_ovr_q;

endmodule
